rx_word_assembler_mc: RTL and testbench

//  Multi-lane successor of the single-lane Timepix3 receiver word path. Takes NUM_LANES

---
 rtl/rx_word_assembler_mc.sv | 181 ++++++++++++++++++
 tb/tb_rx_word_assembler_mc.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_word_assembler_mc.sv
// Multi-lane 8b10b word assembler: per-lane byte packing, round-robin merge into a shared FWFT FIFO.
// Optional feature macro RX_ASM_TIMESTAMP_EN appends a 16-bit WCLK stamp to every word.
module rx_word_assembler_mc #(
  parameter  int NUM_LANES  = 8,
  parameter  int BYTES      = 6,
  parameter  int FIFO_DEPTH = 64,
  parameter  int CNT_W      = 8,
  localparam int LID_W      = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int AW         = $clog2(FIFO_DEPTH),
`ifdef RX_ASM_TIMESTAMP_EN
  localparam int TS_W       = 16,
`else
  localparam int TS_W       = 0,
`endif
  localparam int HW         = 8*BYTES + TS_W,
  localparam int OUT_W      = LID_W + HW
) (
  input  logic                       WCLK,
  input  logic                       RESET,
  input  logic                       err_reset,
  input  logic [NUM_LANES-1:0]       lane_en,
  input  logic [NUM_LANES-1:0]       sym_valid,
  input  logic [NUM_LANES-1:0]       sym_k,
  input  logic [NUM_LANES-1:0]       sym_err,
  input  logic [8*NUM_LANES-1:0]     sym_data,
  output logic [OUT_W-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       fifo_full,
  output logic [AW:0]                fifo_size,
  output logic [CNT_W*NUM_LANES-1:0] lost_err_cnt,
  output logic [CNT_W*NUM_LANES-1:0] decoder_err_cnt
);

  localparam int BC_W = $clog2(BYTES);
  localparam int PW   = 8*(BYTES-1);

  logic [NUM_LANES-1:0] pend_vec;
  logic [HW-1:0]        hold_w [NUM_LANES];
  logic                 grant_vld;
  logic [LID_W-1:0]     grant_id;
  logic [LID_W-1:0]     scan_idx;
  logic [LID_W-1:0]     rr_q;
  logic                 can_write;
  logic                 pop;

  logic [OUT_W-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_q, rd_q;
  logic [AW:0]          size_q;

`ifdef RX_ASM_TIMESTAMP_EN
  logic [15:0] ts_q;

  always_ff @(posedge WCLK) begin
    if (RESET) ts_q <= '0;
    else       ts_q <= ts_q + 16'd1;
  end
`endif

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [7:0]       byte_in;
    logic             gnt;
    logic [BC_W-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]    part_q, part_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] lost_q, lost_d;
    logic [CNT_W-1:0] derr_q, derr_d;

    assign byte_in = sym_data[8*g +: 8];
    assign gnt     = grant_vld && (grant_id == LID_W'(g));

    // Bytes shift in MSB-first, so the first byte of a word lands in the top byte.
    always_comb begin
      cnt_d  = cnt_q;
      part_d = part_q;
      hold_d = hold_q;
      pend_d = pend_q && !gnt;
      lost_d = lost_q;
      derr_d = derr_q;
      if (!lane_en[g]) begin
        cnt_d = '0;
      end else if (sym_valid[g]) begin
        if (sym_err[g]) begin
          cnt_d = '0;
          if (derr_q != '1) derr_d = derr_q + 1'b1;
        end else if (sym_k[g]) begin
          cnt_d = '0;
        end else if (cnt_q == BC_W'(BYTES-1)) begin
          cnt_d = '0;
          if (pend_d) begin
            if (lost_q != '1) lost_d = lost_q + 1'b1;
          end else begin
`ifdef RX_ASM_TIMESTAMP_EN
            hold_d = {part_q, byte_in, ts_q};
`else
            hold_d = {part_q, byte_in};
`endif
            pend_d = 1'b1;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          part_d = PW'({part_q, byte_in});
        end
      end
      if (err_reset) begin
        lost_d = '0;
        derr_d = '0;
      end
    end

    always_ff @(posedge WCLK) begin
      if (RESET) begin
        cnt_q  <= '0;
        part_q <= '0;
        hold_q <= '0;
        pend_q <= 1'b0;
        lost_q <= '0;
        derr_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        part_q <= part_d;
        hold_q <= hold_d;
        pend_q <= pend_d;
        lost_q <= lost_d;
        derr_q <= derr_d;
      end
    end

    assign pend_vec[g]                       = pend_q;
    assign hold_w[g]                         = hold_q;
    assign lost_err_cnt[CNT_W*g +: CNT_W]    = lost_q;
    assign decoder_err_cnt[CNT_W*g +: CNT_W] = derr_q;
  end

  assign out_valid = (size_q != '0);
  assign fifo_full = (size_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_size = size_q;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot on the same edge, so a full FIFO still accepts a write.
  assign can_write = !fifo_full || pop;
  assign out_data  = out_valid ? mem_q[rd_q] : '0;

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      scan_idx = LID_W'((int'(rr_q) + k) % NUM_LANES);
      if (!grant_vld && can_write && pend_vec[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
  end

  always_ff @(posedge WCLK) begin
    if (grant_vld) mem_q[wr_q] <= {grant_id, hold_w[grant_id]};
  end

  always_ff @(posedge WCLK) begin
    if (RESET) begin
      wr_q   <= '0;
      rd_q   <= '0;
      size_q <= '0;
      rr_q   <= '0;
    end else begin
      if (grant_vld) begin
        wr_q <= wr_q + 1'b1;
        rr_q <= LID_W'((int'(grant_id) + 1) % NUM_LANES);
      end
      if (pop) rd_q <= rd_q + 1'b1;
      case ({grant_vld, pop})
        2'b10:   size_q <= size_q + 1'b1;
        2'b01:   size_q <= size_q - 1'b1;
        default: size_q <= size_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_word_assembler_mc.sv
// Bench for rx_word_assembler_mc: directed scenarios plus randomized traffic against a queue-based model.
module tb_rx_word_assembler_mc;

  localparam int NL   = 8;
  localparam int BY   = 6;
  localparam int DEP  = 64;
  localparam int CW   = 8;
  localparam int LW   = 3;
  localparam int AWB  = 6;
`ifdef RX_ASM_TIMESTAMP_EN
  localparam int TSW  = 16;
`else
  localparam int TSW  = 0;
`endif
  localparam int HW   = 8*BY + TSW;
  localparam int OW   = LW + HW;
  localparam int MAXC = (1 << CW) - 1;

  logic            WCLK = 1'b0;
  logic            RESET = 1'b1;
  logic            err_reset = 1'b0;
  logic [NL-1:0]   lane_en = '1;
  logic [NL-1:0]   sym_valid = '0;
  logic [NL-1:0]   sym_k = '0;
  logic [NL-1:0]   sym_err = '0;
  logic [8*NL-1:0] sym_data = '0;
  logic [OW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic            fifo_full;
  logic [AWB:0]    fifo_size;
  logic [CW*NL-1:0] lost_err_cnt;
  logic [CW*NL-1:0] decoder_err_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  rx_word_assembler_mc dut (
    .WCLK(WCLK), .RESET(RESET), .err_reset(err_reset), .lane_en(lane_en),
    .sym_valid(sym_valid), .sym_k(sym_k), .sym_err(sym_err), .sym_data(sym_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_full(fifo_full), .fifo_size(fifo_size),
    .lost_err_cnt(lost_err_cnt), .decoder_err_cnt(decoder_err_cnt)
  );

  always #5 WCLK = ~WCLK;

  // Reference model: words as integers, the shared FIFO as a queue.
  logic [OW-1:0]   m_fifo[$];
  logic [8*BY-1:0] m_acc [NL];
  int              m_cnt [NL];
  bit              m_pend[NL];
  logic [HW-1:0]   m_hold[NL];
  int              m_lost[NL];
  int              m_derr[NL];
  int              m_rr;
  int              m_ts;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit pop, can;
    int g;
    logic [8*BY-1:0] w;
    if (RESET) begin
      m_fifo.delete();
      m_rr = 0;
      m_ts = 0;
      for (int i = 0; i < NL; i++) begin
        m_acc[i] = '0; m_cnt[i] = 0; m_pend[i] = 0; m_hold[i] = '0;
        m_lost[i] = 0; m_derr[i] = 0;
      end
      return;
    end
    pop = out_ready && (m_fifo.size() != 0);
    can = (m_fifo.size() < DEP) || pop;
    g = -1;
    if (can)
      for (int k = 0; k < NL; k++)
        if (g < 0 && m_pend[(m_rr + k) % NL]) g = (m_rr + k) % NL;
    if (pop) void'(m_fifo.pop_front());
    if (g >= 0) begin
      m_fifo.push_back({LW'(g), m_hold[g]});
      m_pend[g] = 0;
      m_rr = (g + 1) % NL;
    end
    for (int i = 0; i < NL; i++) begin
      if (!lane_en[i]) m_cnt[i] = 0;
      else if (sym_valid[i]) begin
        if (sym_err[i]) begin
          m_cnt[i] = 0;
          if (m_derr[i] < MAXC) m_derr[i]++;
        end else if (sym_k[i]) begin
          m_cnt[i] = 0;
        end else begin
          w = (m_acc[i] << 8) | (8*BY)'(sym_data[8*i +: 8]);
          m_acc[i] = w;
          m_cnt[i]++;
          if (m_cnt[i] == BY) begin
            m_cnt[i] = 0;
            if (m_pend[i]) begin
              if (m_lost[i] < MAXC) m_lost[i]++;
            end else begin
`ifdef RX_ASM_TIMESTAMP_EN
              m_hold[i] = {w, 16'(m_ts)};
`else
              m_hold[i] = w;
`endif
              m_pend[i] = 1;
            end
          end
        end
      end
    end
    if (err_reset)
      for (int i = 0; i < NL; i++) begin m_lost[i] = 0; m_derr[i] = 0; end
    m_ts = (m_ts + 1) & 16'hFFFF;
  endtask

  always @(posedge WCLK) model_step();

  always @(negedge WCLK) begin
    logic [CW*NL-1:0] el, ed;
    if (chk_on) begin
      chk("out_valid", out_valid, m_fifo.size() != 0);
      chk("out_data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : '0);
      chk("fifo_full", fifo_full, m_fifo.size() == DEP);
      chk("fifo_size", fifo_size, m_fifo.size());
      for (int i = 0; i < NL; i++) begin
        el[CW*i +: CW] = CW'(m_lost[i]);
        ed[CW*i +: CW] = CW'(m_derr[i]);
      end
      chk("lost_err_cnt", lost_err_cnt, el);
      chk("decoder_err_cnt", decoder_err_cnt, ed);
    end
  end

  task automatic tick();
    @(negedge WCLK);
  endtask

  task automatic idle();
    sym_valid = '0; sym_k = '0; sym_err = '0; sym_data = '0;
  endtask

  task automatic do_reset();
    idle();
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
  endtask

  // Drive one symbol on every lane in mask for one cycle; data per lane = base + 16*lane.
  task automatic drive(input logic [NL-1:0] mask, input logic [7:0] d, input bit k, input bit e,
                       input bit lane_off);
    idle();
    for (int i = 0; i < NL; i++)
      if (mask[i]) begin
        sym_valid[i] = 1'b1;
        sym_k[i] = k;
        sym_err[i] = e;
        sym_data[8*i +: 8] = lane_off ? 8'(d + 8'(16*i)) : d;
      end
    tick();
    idle();
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    chk(nm, out_valid, 1'b1);
  endtask

  initial begin
    logic [7:0] t1 [6];
    int rdy_pct;
    t1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    do_reset();
    chk_on = 1'b1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_size", fifo_size, 0);
    chk("rst_data", out_data, 0);
    chk("rst_full", fifo_full, 1'b0);

    // Lane 0 word, two-cycle latency to out_valid
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) drive(8'h01, t1[j], 0, 0, 0);
    chk("t1_lat1", out_valid, 1'b0);
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data[OW-1 -: LW+48], {LW'(0), 48'h112233445566});
    tick();

    // Lane 2: partial word aborted by a K character
    drive(8'h04, 8'hAA, 0, 0, 0);
    drive(8'h04, 8'hBB, 0, 0, 0);
    drive(8'h04, 8'hBC, 1, 0, 0);
    for (int j = 1; j <= 6; j++) drive(8'h04, 8'(j), 0, 0, 0);
    wait_valid("t2_wait");
    chk("t2_data", out_data[OW-1 -: LW+48], {LW'(2), 48'h010203040506});
    chk("t2_derr", decoder_err_cnt[CW*2 +: CW], 0);
    tick(); tick();
    chk("t2_single", out_valid, 1'b0);

    // Lanes 1,3,5 complete together: emitted 1,3,5; then lanes 0,6 -> 6 first
    do_reset();
    out_ready = 1'b1;
    for (int j = 1; j <= 6; j++) drive(8'b0010_1010, 8'(j), 0, 0, 1);
    tick();
    chk("t3_id1", out_data[OW-1 -: LW], 1);
    chk("t3_data1", out_data[OW-1 -: LW+48], {LW'(1), 48'h111213141516});
    tick();
    chk("t3_id3", out_data[OW-1 -: LW], 3);
    tick();
    chk("t3_id5", out_data[OW-1 -: LW], 5);
    tick();
    chk("t3_empty", out_valid, 1'b0);
    for (int j = 1; j <= 6; j++) drive(8'b0100_0001, 8'(j), 0, 0, 1);
    tick();
    chk("t3_id6", out_data[OW-1 -: LW], 6);
    tick();
    chk("t3_id0", out_data[OW-1 -: LW], 0);
    tick();

    // Lane 4 overflow with the consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int w = 0; w < 70; w++)
      for (int j = 0; j < 6; j++) drive(8'h10, 8'(w*6 + j), 0, 0, 0);
    tick(); tick();
    chk("t4_full", fifo_full, 1'b1);
    chk("t4_size", fifo_size, 64);
    chk("t4_lost", lost_err_cnt[CW*4 +: CW], 5);
    chk("t4_head", out_data[OW-1 -: LW+48], {LW'(4), 48'h000102030405});
    err_reset = 1'b1;
    tick();
    err_reset = 1'b0;
    chk("t4_errrst", lost_err_cnt[CW*4 +: CW], 0);
    out_ready = 1'b1;
    for (int n = 0; n < 70; n++) tick();
    chk("t4_drained", fifo_size, 0);

    // Decoder error saturation, then RESET in mid-word
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 300; n++) drive(8'h80, 8'h00, 0, 1, 0);
    chk("t5_sat", decoder_err_cnt[CW*7 +: CW], 255);
    for (int j = 0; j < 3; j++) drive(8'h80, 8'h50, 0, 0, 0);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t5_rstcnt", decoder_err_cnt[CW*7 +: CW], 0);
    for (int j = 1; j <= 6; j++) drive(8'h80, 8'(8'hA0 + j), 0, 0, 0);
    tick(); tick(); tick();
    chk("t5_size", fifo_size, 1);
    chk("t5_data", out_data[OW-1 -: LW+48], {LW'(7), 48'hA1A2A3A4A5A6});

    // Randomized traffic
    rdy_pct = 90;
    for (int n = 0; n < 3000; n++) begin
      if (n % 400 == 0) rdy_pct = (n / 400) % 2 ? 15 : 90;
      for (int i = 0; i < NL; i++) begin
        lane_en[i]   = ($urandom_range(0, 99) < 95);
        sym_valid[i] = ($urandom_range(0, 99) < 60);
        sym_k[i]     = ($urandom_range(0, 99) < 4);
        sym_err[i]   = ($urandom_range(0, 99) < 3);
        sym_data[8*i +: 8] = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      err_reset = ($urandom_range(0, 199) == 0);
      RESET     = ($urandom_range(0, 999) == 0);
      tick();
    end
    idle();
    lane_en = '1;
    err_reset = 1'b0;
    RESET = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 80; n++) tick();
    chk("final_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
